savior_key_direction_ctrl: RTL and testbench



---
 rtl/savior_key_direction_ctrl.sv | 109 ++++++++++
 tb/tb_savior_key_direction_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/savior_key_direction_ctrl.sv
// Keypad front end for the savior: debounces direction keys against video frames,
// emits active-low move commands, freezes movement across level starts and counts accepted presses.
module savior_key_direction_ctrl #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned MOVE_CNT_MAX    = 4095,
  parameter logic [3:0]  KEY_RIGHT       = 4'd6,
  parameter logic [3:0]  KEY_LEFT        = 4'd4,
  parameter logic [3:0]  KEY_UP          = 4'd2,
  parameter logic [3:0]  KEY_DOWN        = 4'd8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        startOfFrame,
  input  logic [3:0]  keyPad,
  input  logic        keyIsPressed,
  input  logic        startLevel2,
  input  logic        startLevel3,
  output logic        moveRight,
  output logic        moveLeft,
  output logic        moveUp,
  output logic        keyActive,
  output logic [11:0] moveCount
);

  localparam logic [3:0]  DebounceTarget = 4'(DEBOUNCE_FRAMES);
  localparam logic [11:0] CountMax       = 12'(MOVE_CNT_MAX);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, ACTIVE, LOCKOUT} state_t;

  state_t      state, stateNext;
  logic [3:0]  debounceCnt, debounceCntNext;
  logic [3:0]  latchedCode, latchedCodeNext;
  logic [11:0] moveCountNext;
  logic        moveRightNext, moveLeftNext, moveUpNext, keyActiveNext;
  logic        dirValid, keyHeld;

  always_comb begin
    dirValid = keyIsPressed && ((keyPad == KEY_RIGHT) || (keyPad == KEY_LEFT) ||
                                (keyPad == KEY_UP)    || (keyPad == KEY_DOWN));
    keyHeld  = keyIsPressed && (keyPad == latchedCode);

    stateNext       = state;
    debounceCntNext = debounceCnt;
    latchedCodeNext = latchedCode;
    moveCountNext   = moveCount;

    case (state)
      IDLE: begin
        if (dirValid) begin
          latchedCodeNext = keyPad;
          debounceCntNext = 4'd0;
          stateNext       = DEBOUNCE;
        end
      end
      DEBOUNCE: begin
        if (!keyHeld) begin
          stateNext = IDLE;
        end else if (startOfFrame) begin
          debounceCntNext = debounceCnt + 4'd1;
          if (debounceCntNext == DebounceTarget) begin
            stateNext = ACTIVE;
            if (moveCount != CountMax) moveCountNext = moveCount + 12'd1;
          end
        end
      end
      ACTIVE: begin
        if (!keyHeld) stateNext = IDLE;
      end
      LOCKOUT: begin
        if (startOfFrame && !keyIsPressed) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase

    // A level start overrides whatever the state logic decided, but keeps the score.
    if (startLevel2 || startLevel3) begin
      stateNext       = LOCKOUT;
      debounceCntNext = 4'd0;
    end

    keyActiveNext = (stateNext == ACTIVE);
    moveRightNext = !(keyActiveNext && (latchedCodeNext == KEY_RIGHT));
    moveLeftNext  = !(keyActiveNext && ((latchedCodeNext == KEY_LEFT) || (latchedCodeNext == KEY_DOWN)));
    moveUpNext    = !(keyActiveNext && ((latchedCodeNext == KEY_UP)   || (latchedCodeNext == KEY_DOWN)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      debounceCnt <= 4'd0;
      latchedCode <= 4'd0;
      moveCount   <= 12'd0;
      moveRight   <= 1'b1;
      moveLeft    <= 1'b1;
      moveUp      <= 1'b1;
      keyActive   <= 1'b0;
    end else begin
      state       <= stateNext;
      debounceCnt <= debounceCntNext;
      latchedCode <= latchedCodeNext;
      moveCount   <= moveCountNext;
      moveRight   <= moveRightNext;
      moveLeft    <= moveLeftNext;
      moveUp      <= moveUpNext;
      keyActive   <= keyActiveNext;
    end
  end

endmodule

// File: tb/tb_savior_key_direction_ctrl.sv
// Bench for savior_key_direction_ctrl: directed and random keypad traffic compared each cycle
// against a hold-run model of the key debouncer.
module tb_savior_key_direction_ctrl;

  localparam int DB = 2;

  logic        clk = 1'b0;
  logic        reset, startOfFrame, keyIsPressed, startLevel2, startLevel3;
  logic [3:0]  keyPad;
  logic        moveRight, moveLeft, moveUp, keyActive;
  logic [11:0] moveCount;

  int passCount = 0;
  int totalCount = 0;

  // Model: a "run" is an uninterrupted hold of one direction code, measured in frames seen.
  bit lockedM;
  bit runValid;
  int runCode;
  int runSofs;
  int countM;

  savior_key_direction_ctrl dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .keyPad(keyPad),
    .keyIsPressed(keyIsPressed), .startLevel2(startLevel2), .startLevel3(startLevel3),
    .moveRight(moveRight), .moveLeft(moveLeft), .moveUp(moveUp),
    .keyActive(keyActive), .moveCount(moveCount)
  );

  always #5 clk = ~clk;

  function automatic bit isDirection(input int code);
    return (code == 6) || (code == 4) || (code == 2) || (code == 8);
  endfunction

  task automatic modelEdge(input bit rst, input bit sof, input int kp, input bit kip, input bit lvl);
    if (rst) begin
      lockedM = 0; runValid = 0; runSofs = 0; countM = 0;
    end else if (lvl) begin
      lockedM = 1; runValid = 0; runSofs = 0;
    end else if (lockedM) begin
      if (sof && !kip) lockedM = 0;
    end else if (!runValid) begin
      if (kip && isDirection(kp)) begin
        runValid = 1; runCode = kp; runSofs = 0;
      end
    end else if (kip && kp == runCode) begin
      if (sof && runSofs < DB) begin
        runSofs++;
        if (runSofs == DB && countM < 4095) countM++;
      end
    end else begin
      runValid = 0; runSofs = 0;
    end
  endtask

  task automatic check1(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    totalCount++;
    assert (obs === exp) passCount++;
    else $error("[TB] FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic checkOutput();
    bit act;
    act = !lockedM && runValid && (runSofs >= DB);
    check1("keyActive", {11'd0, keyActive}, {11'd0, act});
    check1("moveRight", {11'd0, moveRight}, {11'd0, !(act && runCode == 6)});
    check1("moveLeft",  {11'd0, moveLeft},  {11'd0, !(act && (runCode == 4 || runCode == 8))});
    check1("moveUp",    {11'd0, moveUp},    {11'd0, !(act && (runCode == 2 || runCode == 8))});
    check1("moveCount", moveCount, 12'(countM));
  endtask

  task automatic applyStimulus(input bit rst, input bit sof, input int kp, input bit kip,
                               input bit l2 = 0, input bit l3 = 0);
    reset = rst; startOfFrame = sof; keyPad = 4'(kp); keyIsPressed = kip;
    startLevel2 = l2; startLevel3 = l3;
    @(posedge clk);
    modelEdge(rst, sof, kp, kip, l2 | l3);
    #1 checkOutput();
  endtask

  // One full accepted press of a code followed by a release.
  task automatic pressOnce(input int kp);
    applyStimulus(0, 0, kp, 1);
    applyStimulus(0, 1, kp, 1);
    applyStimulus(0, 1, kp, 1);
    applyStimulus(0, 0, 0, 0);
  endtask

  initial begin
    lockedM = 0; runValid = 0; runCode = 0; runSofs = 0; countM = 0;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0);

    // Right through two frames, then release.
    applyStimulus(0, 0, 6, 1);
    applyStimulus(0, 1, 6, 1);
    applyStimulus(0, 0, 6, 1);
    applyStimulus(0, 1, 6, 1);
    applyStimulus(0, 0, 6, 1);
    applyStimulus(0, 0, 6, 0);

    // Reset in the middle of an active right.
    pressOnce(6);
    applyStimulus(0, 0, 6, 1);
    applyStimulus(0, 1, 6, 1);
    applyStimulus(0, 1, 6, 1);
    applyStimulus(1, 0, 6, 1);
    applyStimulus(0, 0, 0, 0);

    // Down, then switch directly to left.
    applyStimulus(0, 0, 8, 1);
    applyStimulus(0, 1, 8, 1);
    applyStimulus(0, 1, 8, 1);
    applyStimulus(0, 0, 4, 1);
    applyStimulus(0, 0, 4, 1);
    applyStimulus(0, 1, 4, 1);
    applyStimulus(0, 1, 4, 1);
    applyStimulus(0, 0, 4, 0);

    // Bounce on up: one frame, one-cycle release, then a fresh debounce.
    applyStimulus(0, 0, 2, 1);
    applyStimulus(0, 1, 2, 1);
    applyStimulus(0, 0, 2, 0);
    applyStimulus(0, 0, 2, 1);
    applyStimulus(0, 1, 2, 1);
    applyStimulus(0, 0, 2, 1);
    applyStimulus(0, 1, 2, 1);

    // Level start while up is active and held; frozen for five frames.
    applyStimulus(0, 0, 2, 1, 1, 0);
    for (int f = 0; f < 5; f++) begin
      applyStimulus(0, 1, 2, 1);
      applyStimulus(0, 0, 2, 1);
    end
    applyStimulus(0, 0, 2, 0);
    applyStimulus(0, 1, 2, 0);
    applyStimulus(0, 0, 2, 1);
    applyStimulus(0, 1, 2, 1);
    applyStimulus(0, 1, 2, 1);
    applyStimulus(0, 0, 2, 1, 0, 1);
    applyStimulus(0, 0, 2, 1, 0, 1);
    applyStimulus(0, 1, 0, 0);

    // Invalid code held for ten frames.
    for (int f = 0; f < 10; f++) begin
      applyStimulus(0, 1, 5, 1);
      applyStimulus(0, 0, 5, 1);
    end

    // Random traffic: sticky key holds, sparse frames and level starts.
    begin
      int kp; bit kip;
      kp = 6; kip = 0;
      for (int i = 0; i < 600; i++) begin
        int codes[6] = '{6, 4, 2, 8, 5, 0};
        if ($urandom_range(0, 5) == 0) kp = codes[$urandom_range(0, 5)];
        if ($urandom_range(0, 6) == 0) kip = !kip;
        applyStimulus(($urandom_range(0, 299) == 0), ($urandom_range(0, 3) == 0), kp, kip,
                      ($urandom_range(0, 99) == 0), ($urandom_range(0, 99) == 0));
      end
    end

    // Drive the counter to saturation and one beyond.
    applyStimulus(1, 0, 0, 0);
    for (int n = 0; n < 4096; n++) pressOnce((n % 2) ? 8 : 6);
    check1("saturated", moveCount, 12'd4095);
    applyStimulus(1, 0, 0, 0);

    $display("[TB] %0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
